// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage with a one-entry fetch buffer.
//
// Walks a 16-bit byte-addressed instruction stream, one memory request at a
// time, and hands each instruction with its successor address (addr + 2) to
// the fetch register. A taken branch/jump (Redirect) restarts the stream at
// RedirectPC. Any response belonging to the abandoned stream is discarded.
//
// Optional feature (macro FETCH_BYPASS_EN): a zero-wait response is forwarded
// straight to the fetch register when it is not stalled, so one instruction
// per cycle. Without the macro every instruction goes through the buffer.
//
// Ports
//   clk, rst      clock (rising edge) and asynchronous active-high reset
//   Stall         fetch register holding; buffered instruction not consumed
//   Redirect      restart the fetch stream at RedirectPC (beats Stall)
//   RedirectPC    16-bit redirect target
//   imem_req      memory request, held until the ack edge
//   imem_addr     memory byte address, stable while imem_req is high
//   imem_ack      one-cycle response pulse; imem_rdata valid with it
//   imem_rdata    16-bit instruction word
//   InstructOut   instruction to the fetch register (NOP when none)
//   NextPCOut     address of that instruction plus 2
//   o_dbg_state   current FSM state, for debug and checkers
//
// Memory handshake: imem_req acts as valid and imem_ack as the accepting
// response. Once imem_req rises, imem_req and imem_addr stay constant up to
// and including the cycle in which imem_ack=1; the request completes on that
// edge. Only one request is ever outstanding, and imem_ack is only honoured
// while imem_req is high.

module fetch_unit #(
  parameter logic [15:0] NOP = 16'hE800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [15:0] RedirectPC,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] InstructOut,
  output logic [15:0] NextPCOut,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FULL = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_pc;
  logic [15:0] w_pc_nxt;
  logic [15:0] r_req_addr;
  logic [15:0] w_req_addr_nxt;
  logic [15:0] r_buf_instr;
  logic [15:0] w_buf_instr_nxt;
  logic [15:0] r_buf_pcp2;
  logic [15:0] w_buf_pcp2_nxt;
  logic        r_buf_valid;
  logic        w_buf_valid_nxt;

  // Successor of the address being fetched; 16-bit wrap is intended.
  logic [15:0] w_req_pcp2;
  assign w_req_pcp2 = r_req_addr + 16'd2;

  // Forward a response straight to the fetch register this cycle.
  logic w_bypass;
`ifdef FETCH_BYPASS_EN
  assign w_bypass = (r_state == S_REQ) && imem_ack && !Redirect && !Stall;
`else
  assign w_bypass = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= 16'h0000;
      r_req_addr  <= 16'h0000;
      r_buf_instr <= NOP;
      r_buf_pcp2  <= 16'h0000;
      r_buf_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_req_addr  <= w_req_addr_nxt;
      r_buf_instr <= w_buf_instr_nxt;
      r_buf_pcp2  <= w_buf_pcp2_nxt;
      r_buf_valid <= w_buf_valid_nxt;
    end
  end

  // Next-state logic. Redirect is tested first in every state.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_req_addr_nxt  = r_req_addr;
    w_buf_instr_nxt = r_buf_instr;
    w_buf_pcp2_nxt  = r_buf_pcp2;
    w_buf_valid_nxt = r_buf_valid;

    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        if (Redirect) begin
          w_pc_nxt       = RedirectPC;
          w_req_addr_nxt = RedirectPC;
        end else begin
          w_req_addr_nxt = r_pc;
        end
      end

      S_REQ: begin
        if (Redirect) begin
          w_pc_nxt = RedirectPC;
          if (imem_ack) begin
            // Response is stale; reissue immediately at the target.
            w_req_addr_nxt = RedirectPC;
          end else begin
            // Request must still complete on its original address.
            w_state_nxt = S_DROP;
          end
        end else if (imem_ack) begin
          if (w_bypass) begin
            w_pc_nxt       = w_req_pcp2;
            w_req_addr_nxt = w_req_pcp2;
          end else begin
            w_buf_instr_nxt = imem_rdata;
            w_buf_pcp2_nxt  = w_req_pcp2;
            w_buf_valid_nxt = 1'b1;
            w_pc_nxt        = w_req_pcp2;
            w_state_nxt     = S_FULL;
          end
        end
      end

      S_DROP: begin
        if (Redirect) begin
          w_pc_nxt = RedirectPC;
        end
        if (imem_ack) begin
          // Follow the newest target, including one arriving this cycle.
          w_req_addr_nxt = w_pc_nxt;
          w_state_nxt    = S_REQ;
        end
      end

      S_FULL: begin
        if (Redirect) begin
          w_buf_valid_nxt = 1'b0;
          w_pc_nxt        = RedirectPC;
          w_req_addr_nxt  = RedirectPC;
          w_state_nxt     = S_REQ;
        end else if (!Stall) begin
          w_buf_valid_nxt = 1'b0;
          w_req_addr_nxt  = r_pc;
          w_state_nxt     = S_REQ;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs. NextPCOut tracks the buffer even while a bubble is shown.
  always_comb begin
    InstructOut = NOP;
    NextPCOut   = r_buf_pcp2;
    if (w_bypass) begin
      InstructOut = imem_rdata;
      NextPCOut   = w_req_pcp2;
    end else if (r_buf_valid && !Redirect) begin
      InstructOut = r_buf_instr;
    end
  end

  assign imem_req    = (r_state == S_REQ) || (r_state == S_DROP);
  assign imem_addr   = r_req_addr;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit.
//
// A behavioural memory answers requests after a programmable latency with
// data derived from the address. The reference model is the architectural
// instruction stream: each consumed instruction must be the one at the
// expected address, which advances by 2 per consumption and jumps to the
// target on every Redirect. A protocol monitor checks that a pending request
// keeps imem_req and imem_addr stable. Directed steps cover reset, stall,
// redirect cases, address wrap and reset mid-request; a random phase follows.

module tb_fetch_unit;

  localparam logic [15:0] NOP = 16'hE800;
`ifdef FETCH_BYPASS_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        Stall;
  logic        Redirect;
  logic [15:0] RedirectPC;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] InstructOut;
  logic [15:0] NextPCOut;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  fetch_unit #(.NOP(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .Stall       (Stall),
    .Redirect    (Redirect),
    .RedirectPC  (RedirectPC),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .InstructOut (InstructOut),
    .NextPCOut   (NextPCOut),
    .o_dbg_state (dbg_state)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Values applied at the next negedge
  logic        d_rst   = 1'b1;
  logic        d_stall = 1'b0;
  logic        d_redir = 1'b0;
  logic [15:0] d_rpc   = 16'h0000;

  // Memory model
  int  mem_lat   = 0;
  bit  rand_lat  = 1'b0;
  bit  force_ack = 1'b0;
  bit  mem_busy  = 1'b0;
  int  wait_left = 0;

  // Reference stream and monitor state
  logic [15:0] exp_pc    = 16'h0000;
  bit          prev_pend = 1'b0;
  logic [15:0] prev_addr = 16'h0000;
  bit          last_ack;
  bit          last_cons;
  logic [15:0] last_ack_addr;
  int          n_cons = 0;

  logic [15:0] exp_q[$];
  logic [15:0] got_addr_q[$];
  logic [15:0] got_out_q[$];
  logic [15:0] got_npc_q[$];
  int          cons_idx_q[$];

  function automatic logic [15:0] mem_data(input logic [15:0] a);
    if (a == 16'h0008) return 16'h1234;
    return (a ^ 16'h5A5A) & 16'h7FFF;  // bit 15 clear: never equals NOP
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs at negedge, answer memory, then check the stream.
  task automatic tick();
    @(negedge clk);
    rst        = d_rst;
    Stall      = d_stall;
    Redirect   = d_redir;
    RedirectPC = d_rpc;
    #1;
    last_ack   = 1'b0;
    last_cons  = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 16'($urandom);
    if (rst) begin
      mem_busy = 1'b0;
    end else if (force_ack) begin
      imem_ack   = 1'b1;
      imem_rdata = 16'hBEEF;
      force_ack  = 1'b0;
    end else if (imem_req) begin
      if (!mem_busy) begin
        mem_busy  = 1'b1;
        wait_left = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
      end
      if (wait_left == 0) begin
        imem_ack      = 1'b1;
        imem_rdata    = mem_data(imem_addr);
        mem_busy      = 1'b0;
        last_ack      = 1'b1;
        last_ack_addr = imem_addr;
      end else begin
        wait_left--;
      end
    end else begin
      mem_busy = 1'b0;
    end
    #1;
    if (rst) begin
      exp_pc    = 16'h0000;
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        check1("req_held", imem_req, 1'b1);
        check("addr_stable", imem_addr, prev_addr);
      end
      prev_pend = imem_req && !imem_ack;
      prev_addr = imem_addr;
      if (InstructOut !== NOP && !Stall) begin
        last_cons = 1'b1;
        n_cons++;
        check("stream_npc", NextPCOut, exp_pc + 16'd2);
        check("stream_data", InstructOut, mem_data(exp_pc));
        exp_pc = exp_pc + 16'd2;
      end
      if (Redirect) exp_pc = RedirectPC;
    end
  endtask

  task automatic do_reset();
    d_rst = 1'b1; d_stall = 1'b0; d_redir = 1'b0;
    tick();
    tick();
    d_rst = 1'b0;
    tick();
  endtask

  task automatic wait_out_valid(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (InstructOut !== NOP) begin
        got = 1'b1;
        break;
      end
    end
    check1(tag, got, 1'b1);
  endtask

  initial begin
    logic [15:0] r16;
    int cons_before;
    bit got;

    rst = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectPC = 16'h0000;
    imem_ack = 1'b0; imem_rdata = 16'h0000;

    // Reset values
    d_rst = 1'b1;
    tick();
    tick();
    check1("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, 16'h0000);
    check("rst_out", InstructOut, NOP);
    check("rst_npc", NextPCOut, 16'h0000);

    // Zero-wait stream from reset: requests 0,2,4; outputs GAP cycles apart
    d_rst = 1'b0; d_stall = 1'b0; mem_lat = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_ack && got_addr_q.size() < 3) got_addr_q.push_back(last_ack_addr);
      if (last_cons) begin
        cons_idx_q.push_back(i);
        got_out_q.push_back(InstructOut);
        got_npc_q.push_back(NextPCOut);
      end
      if (cons_idx_q.size() == 3) break;
    end
    exp_q = '{16'h0000, 16'h0002, 16'h0004};
    check_int("s1_cons_count", cons_idx_q.size(), 3);
    for (int k = 0; k < 3; k++) begin
      check("s1_addr", (k < got_addr_q.size()) ? got_addr_q[k] : 16'hxxxx, exp_q[k]);
      check("s1_out", (k < got_out_q.size()) ? got_out_q[k] : 16'hxxxx, mem_data(exp_q[k]));
      check("s1_npc", (k < got_npc_q.size()) ? got_npc_q[k] : 16'hxxxx, exp_q[k] + 16'd2);
    end
    check_int("s1_first_latency", (cons_idx_q.size() > 0) ? cons_idx_q[0] : -1, GAP);
    for (int k = 1; k < 3; k++)
      check_int("s1_gap", (cons_idx_q.size() > k) ? cons_idx_q[k] - cons_idx_q[k-1] : -1, GAP);

    // Redirect together with Stall in S_FULL, then a stalled buffer at addr 8
    do_reset();
    d_stall = 1'b1;
    wait_out_valid("rs_fill_timeout");
    check("rs_fill_out", InstructOut, mem_data(16'h0000));
    d_redir = 1'b1; d_rpc = 16'h0008;
    tick();
    check("rs_out_nop", InstructOut, NOP);
    check("rs_npc", NextPCOut, 16'h0002);
    d_redir = 1'b0;
    tick();
    check1("rs_req", imem_req, 1'b1);
    check("rs_addr", imem_addr, 16'h0008);
    wait_out_valid("stall_fill_timeout");
    for (int i = 0; i < 3; i++) begin
      check("stall_out", InstructOut, 16'h1234);
      check("stall_npc", NextPCOut, 16'h000A);
      check1("stall_no_req", imem_req, 1'b0);
      tick();
    end
    d_stall = 1'b0;
    tick();
    check("stall_release_out", InstructOut, 16'h1234);
    check1("stall_release_cons", last_cons, 1'b1);
    tick();
    check1("after_release_req", imem_req, 1'b1);
    check("after_release_addr", imem_addr, 16'h000A);

    // Redirect while a request at 6 waits three cycles for its ack
    do_reset();
    d_stall = 1'b1;
    wait_out_valid("rp_fill_timeout");
    mem_lat = 3;
    d_redir = 1'b1; d_rpc = 16'h0006;
    tick();
    d_rpc = 16'h0100;
    tick();
    check1("rp_req_a", imem_req, 1'b1);
    check("rp_addr_a", imem_addr, 16'h0006);
    d_redir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check1("rp_req_wait", imem_req, 1'b1);
      check("rp_addr_wait", imem_addr, 16'h0006);
      check("rp_out_nop", InstructOut, NOP);
    end
    check1("rp_ack_seen", last_ack, 1'b1);
    mem_lat = 0;
    tick();
    check1("rp_new_req", imem_req, 1'b1);
    check("rp_new_addr", imem_addr, 16'h0100);
    wait_out_valid("rp_out_timeout");
    check("rp_out", InstructOut, mem_data(16'h0100));
    check("rp_npc", NextPCOut, 16'h0102);

    // Address wrap at 16'hFFFE
    d_redir = 1'b1; d_rpc = 16'hFFFE;
    tick();
    d_redir = 1'b0;
    wait_out_valid("wrap_timeout");
    check("wrap_out", InstructOut, mem_data(16'hFFFE));
    check("wrap_npc", NextPCOut, 16'h0000);
    d_stall = 1'b0;
    mem_lat = 3;
    tick();
    tick();
    check1("wrap_req", imem_req, 1'b1);
    check("wrap_addr", imem_addr, 16'h0000);

    // Reset mid-request; a late ack in S_IDLE must be ignored
    tick();
    check1("mid_req_pending", imem_req, 1'b1);
    d_rst = 1'b1;
    tick();
    check1("mid_rst_req", imem_req, 1'b0);
    check("mid_rst_addr", imem_addr, 16'h0000);
    check("mid_rst_out", InstructOut, NOP);
    check("mid_rst_npc", NextPCOut, 16'h0000);
    tick();
    d_rst = 1'b0; force_ack = 1'b1; mem_lat = 0;
    tick();
    check("late_ack_out", InstructOut, NOP);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (last_cons) begin
        got = 1'b1;
        break;
      end
    end
    check1("post_rst_timeout", got, 1'b1);
    check("post_rst_out", InstructOut, mem_data(16'h0000));
    check("post_rst_npc", NextPCOut, 16'h0002);

    // Random traffic against the stream model
    rand_lat = 1'b1;
    cons_before = n_cons;
    for (int i = 0; i < 3000; i++) begin
      d_stall = ($urandom_range(0, 9) < 3);
      d_redir = ($urandom_range(0, 15) == 0);
      r16     = 16'($urandom);
      d_rpc   = ($urandom_range(0, 7) == 0) ? 16'hFFFC : {r16[15:1], 1'b0};
      tick();
    end
    check1("random_progress", (n_cons - cons_before) > 100, 1'b1);

    rand_lat = 1'b0; d_stall = 1'b0; d_redir = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
